// File: rtl/fp_mul_core.sv
// Sequential IEEE-754 single-precision multiplier: one mantissa bit per cycle,
// with a fixed 28-cycle latency from accepted start to done, special operands included.
module fp_mul_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] p,
    output logic        of,
    output logic        uf,
    output logic        nanf,
    output logic        inff,
    output logic        dnf,
    output logic        zf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_FIN,
        K_ZERO,
        K_INF,
        K_NAN
    } kind_t;

    typedef struct packed {
        logic [31:0] p;
        logic        of;
        logic        uf;
        logic        nanf;
        logic        inff;
        logic        dnf;
        logic        zf;
    } result_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               sign_q, sign_d;
    kind_t              kind_q, kind_d;
    logic               dn_q, dn_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [47:0]        mcand_q, mcand_d;
    logic [23:0]        mplier_q, mplier_d;
    logic [47:0]        prod_q, prod_d;
    logic [4:0]         cnt_q, cnt_d;
    result_t            res_q, res_d;

    logic [7:0]         ea, eb;
    logic               a_z, b_z, a_den, b_den, a_inf, b_inf, a_nan, b_nan;
    kind_t              kind_u;
    logic signed [9:0]  exp_u;
    logic [24:0]        rnd;
    logic [22:0]        m_r;
    logic signed [9:0]  e_r;

    // Round-to-nearest-even of a product whose leading one sits at bit 46.
    function automatic logic [24:0] round_rne(input logic [47:0] n);
        logic g;
        logic s;
        logic up;
        g  = n[22];
        s  = |n[21:0];
        up = g & (s | n[23]);
        return {1'b0, n[46:23]} + {24'd0, up};
    endfunction

    // Final packing with overflow saturation to inf and underflow flush to zero.
    function automatic result_t pack_result(input logic s, input kind_t k, input logic dn,
                                            input logic signed [9:0] e, input logic [22:0] m);
        result_t r;
        r = '0;
        case (k)
            K_NAN: begin
                r.p    = 32'h7FC0_0000;
                r.nanf = 1'b1;
            end
            K_INF: begin
                r.p    = {s, 8'hFF, 23'd0};
                r.inff = 1'b1;
            end
            K_ZERO: begin
                r.p   = {s, 31'd0};
                r.dnf = dn;
            end
            default: begin
                if (e >= 10'sd255) begin
                    r.p    = {s, 8'hFF, 23'd0};
                    r.of   = 1'b1;
                    r.inff = 1'b1;
                end else if (e <= 10'sd0) begin
                    r.p  = {s, 31'd0};
                    r.uf = 1'b1;
                end else begin
                    r.p = {s, e[7:0], m};
                end
            end
        endcase
        r.zf = (r.p[30:0] == 31'd0);
        return r;
    endfunction

    assign ea    = a_q[30:23];
    assign eb    = b_q[30:23];
    assign a_z   = (ea == 8'd0);
    assign b_z   = (eb == 8'd0);
    assign a_den = a_z && (a_q[22:0] != 23'd0);
    assign b_den = b_z && (b_q[22:0] != 23'd0);
    assign a_inf = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    assign b_inf = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    assign a_nan = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    assign b_nan = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    assign exp_u = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    // Denormals already count as zero here, so inf times denormal becomes NaN.
    always_comb begin
        kind_u = K_FIN;
        if (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) begin
            kind_u = K_NAN;
        end else if (a_inf || b_inf) begin
            kind_u = K_INF;
        end else if (a_z || b_z) begin
            kind_u = K_ZERO;
        end
    end

    assign rnd = round_rne(prod_q);
    assign m_r = rnd[24] ? rnd[23:1] : rnd[22:0];
    assign e_r = rnd[24] ? exp_q + 10'sd1 : exp_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        kind_d   = kind_q;
        dn_d     = dn_q;
        exp_d    = exp_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = S_UNPACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_UNPACK: begin
                sign_d   = a_q[31] ^ b_q[31];
                kind_d   = kind_u;
                dn_d     = a_den | b_den;
                exp_d    = exp_u;
                mcand_d  = {24'd0, ~a_z, a_q[22:0]};
                mplier_d = {~b_z, b_q[22:0]};
                prod_d   = '0;
                cnt_d    = '0;
                state_d  = S_MULT;
            end
            S_MULT: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd23) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                // The bit shifted out lies below the guard, so fold it into the sticky region.
                if (prod_q[47]) begin
                    prod_d = {1'b0, prod_q[47:2], prod_q[1] | prod_q[0]};
                    exp_d  = exp_q + 10'sd1;
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                res_d   = pack_result(sign_q, kind_q, dn_q, e_r, m_r);
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            kind_q   <= K_FIN;
            dn_q     <= 1'b0;
            exp_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            kind_q   <= kind_d;
            dn_q     <= dn_d;
            exp_q    <= exp_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
        end
    end

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done = (state_q == S_DONE);
    assign p    = res_q.p;
    assign of   = res_q.of;
    assign uf   = res_q.uf;
    assign nanf = res_q.nanf;
    assign inff = res_q.inff;
    assign dnf  = res_q.dnf;
    assign zf   = res_q.zf;

endmodule
